// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; reset value selectable.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start qualification, mid-bit data sampling,
// stop-bit check, one-cycle rx_valid pulse with frame_err.
import uart_pkg::*;

module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic                  tick,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  rx_busy
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [4:0]    MID      = 5'(MID_TICK);
    localparam logic [4:0]    OS_LAST  = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]    SB_LAST  = 5'(SB_TICK - 1);

    logic                  rxd_s;
    rx_state_t             state, state_n;
    logic [4:0]            tick_cnt, tick_cnt_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  done_n, fe_n;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        done_n     = 1'b0;
        fe_n       = 1'b0;
        case (state)
            IDLE: begin
                // Start entry does not wait for a tick
                if (!rxd_s) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (tick_cnt == MID) begin
                        if (!rxd_s) begin
                            state_n    = DATA;
                            tick_cnt_n = '0;
                            bit_cnt_n  = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 5'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tick_cnt == OS_LAST) begin
                        shreg_n    = {rxd_s, shreg[DATA_WIDTH-1:1]};
                        tick_cnt_n = '0;
                        if (bit_cnt == LAST_BIT) state_n = STOP;
                        else                     bit_cnt_n = bit_cnt + 1'b1;
                    end else begin
                        tick_cnt_n = tick_cnt + 5'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tick_cnt == SB_LAST) begin
                        done_n  = 1'b1;
                        fe_n    = ~rxd_s;
                        state_n = IDLE;
                    end else begin
                        tick_cnt_n = tick_cnt + 5'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            rx_valid  <= done_n;
            frame_err <= fe_n;
            if (done_n) rx_data <= shreg;
        end
    end

    assign rx_busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: 8N1 instance plus a 7-bit / 2-stop instance.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       tick;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, rx_busy;
    logic [6:0] rx_data7;
    logic       rx_valid7, frame_err7, rx_busy7;

    int tick_div = 4;
    int tcnt = 0;
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tcnt <= (tcnt >= tick_div - 1) ? 0 : tcnt + 1;
    end
    assign tick = (tcnt == 0);

    uart_rx #(.DATA_WIDTH(8), .SB_TICK(16)) u_rx8 (
        .clk(clk), .reset(reset), .rxd(rxd), .tick(tick),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    uart_rx #(.DATA_WIDTH(7), .SB_TICK(32)) u_rx7 (
        .clk(clk), .reset(reset), .rxd(rxd), .tick(tick),
        .rx_data(rx_data7), .rx_valid(rx_valid7), .frame_err(frame_err7), .rx_busy(rx_busy7)
    );

    // Capture each valid pulse with its cycle stamp and the busy level around it
    int         vcnt = 0, vcnt7 = 0;
    logic [7:0] last_data = '0, prev_data = '0;
    logic [6:0] data7 = '0;
    logic       last_fe = 1'b0, fe7 = 1'b0, busy_q = 1'b0, bp = 1'b0, bv = 1'b0;
    int         last_t = 0, prev_t = 0, t7 = 0;

    always @(negedge clk) begin
        busy_q <= rx_busy;
        if (rx_valid) begin
            vcnt      <= vcnt + 1;
            prev_data <= last_data;
            last_data <= rx_data;
            last_fe   <= frame_err;
            prev_t    <= last_t;
            last_t    <= cyc;
            bp        <= busy_q;
            bv        <= rx_busy;
        end
        if (rx_valid7) begin
            vcnt7 <= vcnt7 + 1;
            data7 <= rx_data7;
            fe7   <= frame_err7;
            t7    <= cyc;
        end
    end

    task automatic hold(input logic v, input int nticks);
        rxd = v;
        repeat (nticks * tick_div) @(posedge clk);
        #1;
    endtask

    task automatic align();
        while (tcnt != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [8:0] d, input int nbits, input int stop_ticks,
                              output int t0);
        align();
        t0 = cyc;
        hold(1'b0, 16);
        for (int i = 0; i < nbits; i++) hold(d[i], 16);
        hold(1'b1, stop_ticks);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_fe got=%b exp=0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", rx_busy); end
        checks++; if ({rx_valid7, rx_busy7, rx_data7} !== 9'h000) begin errors++; $display("FAIL reset_rx7 got=%h exp=000", {rx_valid7, rx_busy7, rx_data7}); end
        hold(1'b1, 32);
    endtask

    task automatic test_single();
        int t0, n0;
        n0 = vcnt;
        send_frame(9'h055, 8, 16, t0);
        checks++; if (vcnt !== n0 + 1) begin errors++; $display("FAIL single_count got=%0d exp=%0d", vcnt - n0, 1); end
        checks++; if (last_data !== 8'h55) begin errors++; $display("FAIL single_data got=%h exp=55", last_data); end
        checks++; if (last_fe !== 1'b0) begin errors++; $display("FAIL single_fe got=%b exp=0", last_fe); end
        checks++; if (last_t - t0 !== 609) begin errors++; $display("FAIL single_latency got=%0d exp=609", last_t - t0); end
        checks++; if (bp !== 1'b1) begin errors++; $display("FAIL single_busy_before got=%b exp=1", bp); end
        checks++; if (bv !== 1'b0) begin errors++; $display("FAIL single_busy_at_valid got=%b exp=0", bv); end
        hold(1'b1, 16);
    endtask

    task automatic test_back_to_back();
        int t0, t1, n0;
        n0 = vcnt;
        send_frame(9'h0A3, 8, 16, t0);
        send_frame(9'h00F, 8, 16, t1);
        checks++; if (vcnt !== n0 + 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", vcnt - n0); end
        checks++; if (prev_data !== 8'hA3) begin errors++; $display("FAIL b2b_data0 got=%h exp=a3", prev_data); end
        checks++; if (last_data !== 8'h0F) begin errors++; $display("FAIL b2b_data1 got=%h exp=0f", last_data); end
        checks++; if (last_t - prev_t !== 640) begin errors++; $display("FAIL b2b_spacing got=%0d exp=640", last_t - prev_t); end
        hold(1'b1, 16);
    endtask

    task automatic test_glitch();
        int n0, nb;
        n0 = vcnt;
        nb = 0;
        align();
        rxd = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (i == 16) rxd = 1'b1;
            if (rx_busy) nb++;
        end
        checks++; if (nb !== 30) begin errors++; $display("FAIL glitch_busy_cycles got=%0d exp=30", nb); end
        hold(1'b1, 200);
        checks++; if (vcnt !== n0) begin errors++; $display("FAIL glitch_no_valid got=%0d exp=0", vcnt - n0); end
    endtask

    task automatic test_frame_err();
        int t0, n0;
        logic [7:0] d;
        n0 = vcnt;
        d = 8'hC4;
        align();
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
        hold(1'b0, 10);
        hold(1'b1, 6);
        hold(1'b1, 16);
        checks++; if (vcnt !== n0 + 1) begin errors++; $display("FAIL fe_count got=%0d exp=1", vcnt - n0); end
        checks++; if (last_data !== 8'hC4) begin errors++; $display("FAIL fe_data got=%h exp=c4", last_data); end
        checks++; if (last_fe !== 1'b1) begin errors++; $display("FAIL fe_flag got=%b exp=1", last_fe); end
        send_frame(9'h012, 8, 16, t0);
        checks++; if (last_data !== 8'h12) begin errors++; $display("FAIL fe_next_data got=%h exp=12", last_data); end
        checks++; if (last_fe !== 1'b0 || vcnt !== n0 + 2) begin errors++; $display("FAIL fe_next_flag got=%b cnt=%0d exp=0 cnt=2", last_fe, vcnt - n0); end
        hold(1'b1, 16);
    endtask

    task automatic test_reset_mid();
        int t0, n0;
        n0 = vcnt;
        align();
        hold(1'b0, 16);
        hold(1'b1, 48);
        hold(1'b1, 8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'h000) begin errors++; $display("FAIL rstmid_outputs got=%h exp=000", {rx_data, rx_valid, frame_err, rx_busy}); end
        hold(1'b1, 8 + 64 + 16);
        hold(1'b1, 32);
        checks++; if (vcnt !== n0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", vcnt - n0); end
        send_frame(9'h081, 8, 16, t0);
        checks++; if (last_data !== 8'h81 || vcnt !== n0 + 1) begin errors++; $display("FAIL rstmid_next got=%h cnt=%0d exp=81 cnt=1", last_data, vcnt - n0); end
        checks++; if (last_fe !== 1'b0) begin errors++; $display("FAIL rstmid_next_fe got=%b exp=0", last_fe); end
        hold(1'b1, 16);
    endtask

    task automatic test_dw7();
        int t0, n0;
        pulse_reset();
        hold(1'b1, 32);
        n0 = vcnt7;
        send_frame(9'h05A, 7, 32, t0);
        checks++; if (vcnt7 !== n0 + 1) begin errors++; $display("FAIL dw7_count got=%0d exp=1", vcnt7 - n0); end
        checks++; if (data7 !== 7'h5A) begin errors++; $display("FAIL dw7_data got=%h exp=5a", data7); end
        checks++; if (fe7 !== 1'b0) begin errors++; $display("FAIL dw7_fe got=%b exp=0", fe7); end
        checks++; if (t7 - t0 !== 609) begin errors++; $display("FAIL dw7_latency got=%0d exp=609", t7 - t0); end
        hold(1'b1, 16);
    endtask

    task automatic test_dvsr0();
        int t0, n0;
        tick_div = 1;
        hold(1'b1, 64);
        n0 = vcnt;
        send_frame(9'h03C, 8, 16, t0);
        checks++; if (last_data !== 8'h3C || vcnt !== n0 + 1) begin errors++; $display("FAIL dvsr0_data got=%h cnt=%0d exp=3c cnt=1", last_data, vcnt - n0); end
        checks++; if (last_t - t0 !== 155) begin errors++; $display("FAIL dvsr0_latency got=%0d exp=155", last_t - t0); end
        hold(1'b1, 32);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_dw7();
        test_dvsr0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive stage sitting directly downstream of the baud rate generator inside the `uart` top. It consumes the generator's 16x-oversampling `tick` and the raw `rxd` pin. It synchronises `rxd`, detects and qualifies the start bit, samples each data bit at mid-bit, and checks the stop bit. Each received word is presented as a one-cycle valid pulse, with a frame-error flag.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame, legal range 5–9, sent LSB first.
- `SB_TICK`, default 16: ticks counted in the stop state (16 = one stop bit, 24 = 1.5, 32 = 2).
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high; one clock, no other clock domains.
- `rxd`  in  1: asynchronous serial input, idle high.
- `tick`  in  1: one-`clk`-wide pulse at 16x the baud rate, from `baud_gen`.
- `rx_data`  out  DATA_WIDTH: last received word; holds until the next frame completes.
- `rx_valid`  out  1: one-cycle pulse, asserted when `rx_data` updates.
- `frame_err`  out  1: valid only with `rx_valid`; 1 means the stop bit was sampled low.
- `rx_busy`  out  1: 1 in every state except IDLE.

## Operation
- `rxd` passes through a 2-flop synchroniser; both flops reset to 1. The FSM uses only the synchronised `rxd_s`.
- Registers:
  - `tick_cnt`: 5 bits, wide enough for SB_TICK−1 up to 31.
  - `bit_cnt`: clog2(DATA_WIDTH) bits.
  - `shreg`: DATA_WIDTH bits, shifts right; the new bit enters at the MSB.
- Counters and `shreg` change only on cycles with `tick`=1, except for the IDLE→START entry.
- FSM states and transitions:
  - IDLE: when `rxd_s`=0 (tick not required), go to START and clear `tick_cnt`.
  - START: on tick with `tick_cnt`=7, the middle of the start bit:
    - if `rxd_s`=0, go to DATA and clear `tick_cnt` and `bit_cnt`;
    - if `rxd_s`=1, treat it as a glitch and return to IDLE with no output.
    - On other ticks, increment `tick_cnt`.
  - DATA: on tick with `tick_cnt`=15, shift `rxd_s` into `shreg` and clear `tick_cnt`.
    - If `bit_cnt`=DATA_WIDTH−1, go to STOP; otherwise increment `bit_cnt`.
    - On other ticks, increment `tick_cnt`.
  - STOP: on tick with `tick_cnt`=SB_TICK−1, load `rx_data`←`shreg`, pulse `rx_valid`, set `frame_err`←~`rxd_s`, and go to IDLE.
    - On other ticks, increment `tick_cnt`.
- On a frame error, `rx_data` is still updated with the received bits; no data is suppressed.
- Break condition (`rxd` held low): produces a word of all zeros with `frame_err`=1. After returning to IDLE, the receiver re-enters START immediately and repeats every frame time until the line goes high.
- `rx_valid` has no back-pressure. The consumer must capture on the pulse; an unread word is overwritten silently.
- Reset values: state IDLE, all counters 0, `shreg` 0, `rx_data` 0, `rx_valid` 0, `frame_err` 0, `rx_busy` 0.
- Reset in mid-frame aborts the frame with no output. Reception restarts at the next falling edge seen after reset is released.

## Timing
- `rxd` to `rxd_s` delay: 2 `clk` cycles.
- The falling edge of `rxd_s` moves the FSM to START in the following cycle.
- Sample points:
  - start bit: 8 ticks after entry;
  - data bit n: 8+16·(n+1) ticks after entry;
  - stop bit: 8+16·DATA_WIDTH+SB_TICK ticks after entry.
- `rx_valid` and `frame_err` are registered; they go high in the cycle after the qualifying tick, for exactly one cycle.
- `rx_data` changes in that same cycle and is otherwise stable.
- `rx_busy` falls together with `rx_valid`.
- Ticks spaced 1 cycle apart (DVSR=0) must work. No minimum tick spacing is assumed beyond one cycle.

## Structure
- Shared package `uart_pkg`:
  - state encoding `rx_state_t` {IDLE, START, DATA, STOP};
  - constants `OVERSAMPLE`=16 and `MID_TICK`=7.
- One sub-module, `uart_sync2`: the 2-flop synchroniser, parameterised on reset value (1 here). It is reusable for any other asynchronous input later.
- The rest is a single FSM with its datapath registers, in one always block plus next-state logic.

## Test plan
- Frame 0x55, 8N1, DVSR such that there are 16 ticks per bit -> one `rx_valid` with `rx_data`=0x55, `frame_err`=0, `rx_busy` high from the start edge until the pulse.
- Back-to-back frames 0xA3 then 0x0F with no idle gap -> two pulses exactly 10 bit times apart, with data 0xA3 then 0x0F.
- Low glitch on `rxd` of 4 ticks -> FSM returns to IDLE at tick 7, no `rx_valid`, and `rx_busy` pulses only for the glitch window.
- Frame 0xC4 with the stop bit driven low -> `rx_valid`=1, `rx_data`=0xC4, `frame_err`=1. A following good frame 0x12 gives `frame_err`=0.
- `reset` asserted for one cycle in the middle of data bit 3 of 0xFF -> no output, all outputs 0. The next frame 0x81 is received correctly.
- DATA_WIDTH=7, SB_TICK=32, frame 0x5A -> `rx_data`=0x5A. `rx_valid` arrives 32 ticks after the last data-bit sample.
